// File: rtl/mstr_seq_pkg.sv
// Shared definitions for the master sequencer and its per-rail power-good monitors:
// monitor state encodings, fault codes and default timing constants.
package mstr_seq_pkg;

  // Per-rail monitor states; the numeric values are visible on the debug port.
  typedef enum logic [2:0] {
    RPG_OFF       = 3'd0,
    RPG_RAMP_UP   = 3'd1,
    RPG_ON        = 3'd2,
    RPG_RAMP_DOWN = 3'd3,
    RPG_FAULT     = 3'd4
  } rpg_state_e;

  // Fault codes reported alongside the latched active-low fault.
  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_ON_TMO   = 2'b01;
  localparam logic [1:0] FC_PG_LOST  = 2'b10;
  localparam logic [1:0] FC_PG_STUCK = 2'b11;

  // Default timing in 1 ms ticks, shared with the sequencer's delay values.
  localparam int unsigned DEF_DEBOUNCE_MS       = 32'd2;
  localparam int unsigned DEF_PG_ON_TIMEOUT_MS  = 32'd20;
  localparam int unsigned DEF_PG_OFF_TIMEOUT_MS = 32'd150;

  // Saturating 16-bit increment used by the state timer.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic inc);
    if (inc && (val != 16'hFFFF)) begin
      return val + 16'd1;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/pg_debounce.sv
// Two-flop synchroniser plus tick-based debounce filter for a raw regulator PG.
// The filtered value flips only after the synced value has disagreed with it
// for DEBOUNCE_MS consecutive 1 ms ticks; DEBOUNCE_MS = 0 passes the synced value.
module pg_debounce
  import mstr_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic tick_i,
  input  logic pg_raw_i,
  output logic pg_filt_o
);

  localparam logic [7:0] DEB_LIM = 8'(DEBOUNCE_MS);

  logic       sync1_q;
  logic       sync2_q;
  logic       filt_q;
  logic       filt_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Debounce next-state: count ticks of disagreement, flip on reaching the limit.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (sync2_q == filt_q) begin
      cnt_d = 8'd0;
    end else if (tick_i) begin
      if ((cnt_q + 8'd1) >= DEB_LIM) begin
        filt_d = sync2_q;
        cnt_d  = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Synchroniser and debounce state registers.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      sync1_q <= pg_raw_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pg_filt_o = (DEBOUNCE_MS == 32'd0) ? sync2_q : filt_q;

endmodule

// File: rtl/rail_pwrgd_monitor.sv
// Per-rail power-good supervisor on the responder side of the sequencer's
// enable/PG handshake. Qualifies the regulator PG, enforces on/off windows and
// latches a coded fault that only clears while the rail is disabled.
module rail_pwrgd_monitor
  import mstr_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS       = DEF_DEBOUNCE_MS,
  parameter int unsigned PG_ON_TIMEOUT_MS  = DEF_PG_ON_TIMEOUT_MS,
  parameter int unsigned PG_OFF_TIMEOUT_MS = DEF_PG_OFF_TIMEOUT_MS
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iTick_1ms,
  input  logic       iRail_EN,
  input  logic       iPWRGD_raw,
  input  logic       iFault_Clear,
  output logic       oPWRGD,
  output logic       oFault_N,
  output logic [1:0] oFault_Code,
  output logic [2:0] oDBG_State
);

  localparam logic [15:0] ON_TMO_LIM  = 16'(PG_ON_TIMEOUT_MS);
  localparam logic [15:0] OFF_TMO_LIM = 16'(PG_OFF_TIMEOUT_MS);

  rpg_state_e  state_q;
  logic [15:0] timer_q;
  logic        pwrgd_q;
  logic        fault_n_q;
  logic [1:0]  code_q;
  logic        pg_filt;
  logic        on_tmo;
  logic        off_tmo;

  pg_debounce #(
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) u_pg_debounce (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .tick_i    (iTick_1ms),
    .pg_raw_i  (iPWRGD_raw),
    .pg_filt_o (pg_filt)
  );

  // Window expiry flags, evaluated against the registered timer every cycle.
  always_comb begin
    on_tmo  = (timer_q >= ON_TMO_LIM);
    off_tmo = (timer_q >= OFF_TMO_LIM);
  end

  // Rail FSM with its timer and registered handshake outputs. Any state change
  // zeroes the timer, which also swallows a tick landing on that same edge.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= RPG_OFF;
      timer_q   <= 16'd0;
      pwrgd_q   <= 1'b0;
      fault_n_q <= 1'b1;
      code_q    <= FC_NONE;
    end else begin
      timer_q <= sat_inc16(timer_q, iTick_1ms);
      case (state_q)
        RPG_OFF: begin
          if (iRail_EN) begin
            state_q <= RPG_RAMP_UP;
            timer_q <= 16'd0;
          end else if (pg_filt) begin
            state_q   <= RPG_FAULT;
            timer_q   <= 16'd0;
            fault_n_q <= 1'b0;
            code_q    <= FC_PG_STUCK;
          end
        end
        RPG_RAMP_UP: begin
          // Disable wins over a coincident on-timeout.
          if (!iRail_EN) begin
            state_q <= RPG_RAMP_DOWN;
            timer_q <= 16'd0;
          end else if (pg_filt) begin
            state_q <= RPG_ON;
            timer_q <= 16'd0;
            pwrgd_q <= 1'b1;
          end else if (on_tmo) begin
            state_q   <= RPG_FAULT;
            timer_q   <= 16'd0;
            fault_n_q <= 1'b0;
            code_q    <= FC_ON_TMO;
          end
        end
        RPG_ON: begin
          // Disable wins over a coincident PG loss, so no fault is raised.
          if (!iRail_EN) begin
            state_q <= RPG_RAMP_DOWN;
            timer_q <= 16'd0;
            pwrgd_q <= 1'b0;
          end else if (!pg_filt) begin
            state_q   <= RPG_FAULT;
            timer_q   <= 16'd0;
            pwrgd_q   <= 1'b0;
            fault_n_q <= 1'b0;
            code_q    <= FC_PG_LOST;
          end
        end
        RPG_RAMP_DOWN: begin
          // Re-enable is ignored until the rail has reached OFF.
          if (!pg_filt) begin
            state_q <= RPG_OFF;
            timer_q <= 16'd0;
          end else if (off_tmo) begin
            state_q   <= RPG_FAULT;
            timer_q   <= 16'd0;
            fault_n_q <= 1'b0;
            code_q    <= FC_PG_STUCK;
          end
        end
        RPG_FAULT: begin
          // Clearing with the rail still enabled is refused to prevent auto-restart.
          if (iFault_Clear && !iRail_EN) begin
            state_q   <= RPG_OFF;
            timer_q   <= 16'd0;
            fault_n_q <= 1'b1;
            code_q    <= FC_NONE;
          end
        end
        default: begin
          state_q   <= RPG_OFF;
          timer_q   <= 16'd0;
          pwrgd_q   <= 1'b0;
          fault_n_q <= 1'b1;
          code_q    <= FC_NONE;
        end
      endcase
    end
  end

  assign oPWRGD      = pwrgd_q;
  assign oFault_N    = fault_n_q;
  assign oFault_Code = code_q;
  assign oDBG_State  = state_q;

endmodule

// File: tb/tb_rail_pwrgd_monitor.sv
// Self-checking bench for rail_pwrgd_monitor: directed scenarios plus a random
// phase, all checked every cycle against a behavioural rail model.
module tb_rail_pwrgd_monitor;

  localparam int DEB   = 2;
  localparam int ON_T  = 20;
  localparam int OFF_T = 150;
  localparam int TP    = 10;   // clocks per 1 ms tick (time-compressed)

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick  = 1'b0;
  logic       en    = 1'b0;
  logic       raw   = 1'b0;
  logic       clr   = 1'b0;
  logic       pwrgd;
  logic       fault_n;
  logic [1:0] code;
  logic [2:0] dbg;

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  rail_pwrgd_monitor #(
    .DEBOUNCE_MS       (DEB),
    .PG_ON_TIMEOUT_MS  (ON_T),
    .PG_OFF_TIMEOUT_MS (OFF_T)
  ) dut (
    .iClk         (clk),
    .iRst_n       (rst_n),
    .iTick_1ms    (tick),
    .iRail_EN     (en),
    .iPWRGD_raw   (raw),
    .iFault_Clear (clr),
    .oPWRGD       (pwrgd),
    .oFault_N     (fault_n),
    .oFault_Code  (code),
    .oDBG_State   (dbg)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  // Free-running 1 ms strobe, one clock wide.
  initial begin
    int tc;
    tc = 0;
    forever begin
      @(posedge clk);
      #1;
      tick = (tc == TP - 1);
      tc = (tc == TP - 1) ? 0 : tc + 1;
    end
  end

  // ---------------- behavioural model ----------------
  // States: 0 off, 1 ramping up, 2 on, 3 ramping down, 4 fault.
  logic [1:0] m_sh;      // raw PG seen through two clock delays
  logic       m_filt;
  int         m_dcnt;    // ticks the synced PG has disagreed with the filtered PG
  int         m_state;
  int         m_timer;   // ticks spent in current state (saturating)
  int         m_code;

  function automatic int next_state(int s, logic e, logic f, logic c, int t);
    case (s)
      0:       return e ? 1 : (f ? 4 : 0);
      1:       return !e ? 3 : (f ? 2 : ((t >= ON_T) ? 4 : 1));
      2:       return !e ? 3 : (!f ? 4 : 2);
      3:       return !f ? 0 : ((t >= OFF_T) ? 4 : 3);
      4:       return (c && !e) ? 0 : 4;
      default: return 0;
    endcase
  endfunction

  // Fault reason depends only on where the rail was when it failed.
  function automatic int entry_code(int from);
    case (from)
      1:       return 1;
      2:       return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sh    <= 2'b00;
      m_filt  <= 1'b0;
      m_dcnt  <= 0;
      m_state <= 0;
      m_timer <= 0;
      m_code  <= 0;
    end else begin
      m_sh <= {m_sh[0], raw};
      if (m_sh[1] == m_filt) m_dcnt <= 0;
      else if (tick) begin
        if (m_dcnt + 1 >= DEB) begin
          m_filt <= m_sh[1];
          m_dcnt <= 0;
        end else m_dcnt <= m_dcnt + 1;
      end
      m_state <= next_state(m_state, en, m_filt, clr, m_timer);
      if (next_state(m_state, en, m_filt, clr, m_timer) != m_state) m_timer <= 0;
      else if (tick && m_timer < 65535) m_timer <= m_timer + 1;
      if (next_state(m_state, en, m_filt, clr, m_timer) == 4) begin
        if (m_state != 4) m_code <= entry_code(m_state);
      end else m_code <= 0;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle: {state, pwrgd, fault_n, code} against the model.
  initial begin
    logic [6:0] e;
    forever begin
      @(negedge clk);
      if (!done) begin
        e = {3'(m_state), (m_state == 2), (m_state != 4), 2'(m_code)};
        chk("cycle", {25'd0, dbg, pwrgd, fault_n, code}, {25'd0, e});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_model(input int st, input int budget, input string nm);
    int k;
    k = 0;
    while (m_state != st && k < budget) begin
      step(1);
      k++;
    end
    if (m_state != st) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: wait budget expired, model state %0d required %0d", nm, m_state, st);
    end
  endtask

  task automatic wait_filt(input logic v, input int budget);
    int k;
    k = 0;
    while (m_filt != v && k < budget) begin
      step(1);
      k++;
    end
  endtask

  task automatic clear_fault();
    en = 1'b0;
    raw = 1'b0;
    wait_filt(1'b0, 4 * TP);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clear_to_off", {29'd0, dbg}, 32'd0);
  endtask

  initial begin
    // Reset
    step(3);
    chk("rst_outputs", {25'd0, dbg, pwrgd, fault_n, code}, {25'd0, 3'd0, 1'b0, 1'b1, 2'b00});
    rst_n = 1'b1;
    step(2);

    // 1. Normal on/off
    en = 1'b1;
    step(1);
    chk("t1_ramp_up", {29'd0, dbg}, 32'd1);
    step(5 * TP);
    raw = 1'b1;
    wait_model(2, 6 * TP, "t1_on");
    chk("t1_pwrgd", {31'd0, pwrgd}, 32'd1);
    en = 1'b0;
    step(1);
    chk("t1_ramp_down", {29'd0, dbg}, 32'd3);
    chk("t1_pwrgd_off", {31'd0, pwrgd}, 32'd0);
    step(3 * TP);
    raw = 1'b0;
    wait_model(0, 4 * TP, "t1_off");
    chk("t1_fault_n", {31'd0, fault_n}, 32'd1);

    // 2. On-timeout, refused clear while enabled, then clear
    en = 1'b1;
    wait_model(4, (ON_T + 2) * TP, "t2_fault");
    chk("t2_code", {30'd0, code}, 32'd1);
    chk("t2_fault_n", {31'd0, fault_n}, 32'd0);
    clr = 1'b1;
    step(5);
    chk("t2_clear_blocked", {29'd0, dbg}, 32'd4);
    en = 1'b0;
    step(1);
    clr = 1'b0;
    chk("t2_cleared", {25'd0, dbg, pwrgd, fault_n, code}, {25'd0, 3'd0, 1'b0, 1'b1, 2'b00});

    // 3. Glitch filtered, then real PG loss
    en = 1'b1;
    raw = 1'b1;
    wait_model(2, 6 * TP, "t3_on");
    raw = 1'b0;
    step(TP);
    raw = 1'b1;
    step(4 * TP);
    chk("t3_glitch", {29'd0, dbg}, 32'd2);
    raw = 1'b0;
    wait_model(4, 5 * TP, "t3_fault");
    chk("t3_code", {30'd0, code}, 32'd2);
    chk("t3_pwrgd", {31'd0, pwrgd}, 32'd0);
    clear_fault();

    // 4a. Off-timeout with PG stuck high
    en = 1'b1;
    raw = 1'b1;
    wait_model(2, 6 * TP, "t4_on");
    en = 1'b0;
    wait_model(4, (OFF_T + 3) * TP, "t4_offtmo");
    chk("t4_code", {30'd0, code}, 32'd3);
    clear_fault();
    // 4b. Unexpected PG in OFF
    raw = 1'b1;
    wait_model(4, 5 * TP, "t4_stuck");
    chk("t4_stuck_code", {30'd0, code}, 32'd3);
    clear_fault();

    // 5a. EN falls on the cycle the filtered PG falls in ON
    en = 1'b1;
    raw = 1'b1;
    wait_model(2, 6 * TP, "t5_on");
    raw = 1'b0;
    wait_filt(1'b0, 4 * TP);
    en = 1'b0;
    step(1);
    chk("t5a_ramp_down", {29'd0, dbg}, 32'd3);
    step(1);
    chk("t5a_off", {29'd0, dbg}, 32'd0);
    chk("t5a_no_fault", {31'd0, fault_n}, 32'd1);
    // 5b. EN falls on the on-timeout cycle
    en = 1'b1;
    step(1);
    for (int k = 0; k < (ON_T + 2) * TP && !(m_state == 1 && m_timer >= ON_T); k++) step(1);
    en = 1'b0;
    step(1);
    chk("t5b_ramp_down", {29'd0, dbg}, 32'd3);
    chk("t5b_no_fault", {31'd0, fault_n}, 32'd1);
    step(1);
    chk("t5b_off", {29'd0, dbg}, 32'd0);

    // 6. Async reset mid RAMP_UP and in FAULT
    en = 1'b1;
    step(3 * TP);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rampup", {25'd0, dbg, pwrgd, fault_n, code}, {25'd0, 3'd0, 1'b0, 1'b1, 2'b00});
    en = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);
    chk("t6_off", {29'd0, dbg}, 32'd0);
    raw = 1'b1;
    wait_model(4, 5 * TP, "t6_fault");
    rst_n = 1'b0;
    #1;
    chk("t6_rst_fault", {25'd0, dbg, pwrgd, fault_n, code}, {25'd0, 3'd0, 1'b0, 1'b1, 2'b00});
    raw = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);
    chk("t6_off2", {29'd0, dbg}, 32'd0);
    // Timer restarted from zero: full on-window required after reset.
    en = 1'b1;
    step(ON_T * TP - 2 * TP);
    chk("t6_still_ramp", {29'd0, dbg}, 32'd1);
    en = 1'b0;
    step(2);

    // Random phase
    for (int s = 0; s < 200; s++) begin
      en  = 1'($urandom_range(0, 1));
      raw = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end
      step($urandom_range(1, 4 * TP));
    end

    done = 1'b1;
    step(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
